cm0_pmu_pwr_seq: RTL
====================

# cm0_pmu_pwr_seq

Power-down/power-up sequencer for the Cortex-M0 PMU. It consumes the already-synchronised deep-sleep, wake-up and power-switch-acknowledge signals produced by the PMU two-flop synchronisers. It drives the core sleep-hold handshake and the isolation, retention and power-gate controls in a fixed, counted order. It sits directly downstream of those synchronisers and upstream of the power-switch and isolation cells.

## Interface
- DLY, 4: cycles held in each timed state (ISO, RET, UNRET, UNISO); legal 1..15; 0 behaves as 1.
- CW, 4: counter width; must satisfy DLY < 2^CW.
- SCLK  in  1  PMU clock; free-running, never gated by this block.
- SRESET  in  1  reset; one clock, synchronous and active-high, sampled on SCLK rising edge.
- SLEEPDEEP_S  in  1  core deep-sleep indication, already synchronised to SCLK.
- WAKEUP_S  in  1  wake event (WIC/debug), already synchronised; level, may pulse for 1 cycle.
- SLEEPHOLDACKn  in  1  core acknowledge of sleep hold, active-low, SCLK domain.
- PWRACK_S  in  1  power switch status, synchronised; 1 = domain off, 0 = domain on.
- SLEEPHOLDREQn  out  1  request the core to hold in sleep, active-low.
- ISOLATEn  out  1  clamp core outputs, active-low.
- RETAINn  out  1  save state into retention flops, active-low.
- PWRDOWN  out  1  request power switch off, active-high.
- PMUBUSY  out  1  high in every state except RUN.

## Operation
- States: RUN, HOLD, ISO, RET, PDN, OFF, PUP, UNRET, UNISO, REL.
- RUN: all outputs inactive. SLEEPDEEP_S=1 and WAKEUP_S=0 -> HOLD.
- HOLD: SLEEPHOLDREQn=0.
  - SLEEPHOLDACKn=0 -> ISO.
  - Abort if WAKEUP_S=1 or SLEEPDEEP_S=0 before the ack: -> REL. Abort wins over a simultaneous ack.
- ISO: ISOLATEn=0; after DLY cycles -> RET.
- RET: RETAINn=0; after DLY cycles -> PDN.
- PDN: PWRDOWN=1; wait for PWRACK_S=1 -> OFF.
- OFF: outputs as in PDN. Wake pending -> PUP.
- PUP: PWRDOWN=0; wait for PWRACK_S=0 -> UNRET.
- UNRET: RETAINn=1; after DLY cycles -> UNISO.
- UNISO: ISOLATEn=1; after DLY cycles -> REL.
- REL: SLEEPHOLDREQn=1. Wait for SLEEPHOLDACKn=1 -> RUN.
- Wake latch:
  - Set by WAKEUP_S=1 in any state from ISO through OFF.
  - Cleared on entry to PUP.
  - Once ISO is entered, the sequence always completes to OFF, then powers up at once if the latch is set. There is no mid-sequence reversal.
- Counter: CW bits. Loaded with max(DLY,1)-1 on entry to each timed state; decrements; the state exits on the cycle the counter is 0. Never wraps.
- Controls stay asserted until reversed, cumulatively: in PDN, SLEEPHOLDREQn=0, ISOLATEn=0 and RETAINn=0 are all still held.
- SRESET at any point: immediate return to RUN, counter 0, wake latch 0, all outputs to reset values. This holds mid-sequence, including OFF.

## Timing
- Reset values: SLEEPHOLDREQn=1, ISOLATEn=1, RETAINn=1, PWRDOWN=0, PMUBUSY=0.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Edge E: SLEEPDEEP_S sampled high in RUN. At edge E+1, SLEEPHOLDREQn falls and PMUBUSY rises.
- Ack sampled at edge A: ISOLATEn falls at A+1, RETAINn falls at A+1+DLY, PWRDOWN rises at A+1+2·DLY.
- PWRACK_S=1 sampled at edge P -> OFF at P+1.
- Wake is sampled in OFF at edge W:
  - PWRDOWN falls at W+1.
  - After PWRACK_S=0 is sampled at edge Q, RETAINn rises at Q+1 and ISOLATEn rises at Q+1+DLY.
  - SLEEPHOLDREQn rises at Q+1+2·DLY.
- PWRACK_S waits have no timeout.
- A one-cycle WAKEUP_S pulse during ISO, RET or PDN must not be lost.

## Test plan
- Full cycle, DLY=4: SLEEPDEEP_S=1, ack after 3 cycles, PWRACK_S=1 after 5 cycles, WAKEUP_S pulse 10 cycles later, PWRACK_S=0 after 5 cycles -> output edges exactly at the offsets in Timing; PMUBUSY=0 once SLEEPHOLDACKn returns to 1.
- Abort in HOLD: WAKEUP_S=1 on the same edge SLEEPHOLDACKn falls -> ISOLATEn stays 1, REL then RUN, PWRDOWN never asserted.
- Early wake: 1-cycle WAKEUP_S pulse during RET -> sequence reaches OFF for exactly 1 cycle, then PUP follows.
- DLY=0 and DLY=15: ISOLATEn-to-RETAINn spacing is 1 and 15 cycles respectively.
- Reset in OFF: assert SRESET for 1 cycle -> next edge gives SLEEPHOLDREQn=1, ISOLATEn=1, RETAINn=1, PWRDOWN=0, PMUBUSY=0; sequence restarts on a fresh SLEEPDEEP_S.
- Stalled power switch: PWRACK_S held 0 for 100 cycles in PDN -> stays in PDN with all controls asserted; no output toggles.

Source files
------------

// File: rtl/cm0_pmu_pwr_seq.sv
// Cortex-M0 PMU power sequencer: sleep-hold handshake, then isolation, retention and
// power-gate control in a fixed counted order, and the mirror-image power-up.
module cm0_pmu_pwr_seq #(
  parameter int DLY = 4,
  parameter int CW  = 4
) (
  input  logic SCLK,
  input  logic SRESET,
  input  logic SLEEPDEEP_S,
  input  logic WAKEUP_S,
  input  logic SLEEPHOLDACKn,
  input  logic PWRACK_S,
  output logic SLEEPHOLDREQn,
  output logic ISOLATEn,
  output logic RETAINn,
  output logic PWRDOWN,
  output logic PMUBUSY
);

  typedef enum logic [3:0] {
    ST_RUN, ST_HOLD, ST_ISO, ST_RET, ST_PDN,
    ST_OFF, ST_PUP, ST_UNRET, ST_UNISO, ST_REL
  } state_t;

  localparam int            DLY_EFF  = (DLY < 1) ? 1 : DLY;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DLY_EFF - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wake_q, wake_d;
  logic          req_n_q, req_n_d;
  logic          iso_n_q, iso_n_d;
  logic          ret_n_q, ret_n_d;
  logic          pdn_q, pdn_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    wake_d  = wake_q;

    case (state_q)
      ST_RUN:   if (SLEEPDEEP_S && !WAKEUP_S) state_d = ST_HOLD;
      // An abort request outranks an ack arriving on the same edge.
      ST_HOLD: begin
        if (WAKEUP_S || !SLEEPDEEP_S) begin
          state_d = ST_REL;
        end else if (!SLEEPHOLDACKn) begin
          state_d = ST_ISO;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_ISO: begin
        if (cnt_q == '0) begin
          state_d = ST_RET;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_RET:   if (cnt_q == '0) state_d = ST_PDN;
      ST_PDN:   if (PWRACK_S) state_d = ST_OFF;
      ST_OFF:   if (wake_q || WAKEUP_S) state_d = ST_PUP;
      ST_PUP: begin
        if (!PWRACK_S) begin
          state_d = ST_UNRET;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_UNRET: begin
        if (cnt_q == '0) begin
          state_d = ST_UNISO;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_UNISO: if (cnt_q == '0) state_d = ST_REL;
      ST_REL:   if (SLEEPHOLDACKn) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    // Wakes seen mid power-down are remembered so the sequence can finish, then reverse.
    if (WAKEUP_S && (state_q inside {ST_ISO, ST_RET, ST_PDN, ST_OFF})) wake_d = 1'b1;
    if (state_d == ST_PUP && state_q != ST_PUP) wake_d = 1'b0;

    req_n_d = 1'b1;
    iso_n_d = 1'b1;
    ret_n_d = 1'b1;
    pdn_d   = 1'b0;
    busy_d  = (state_d != ST_RUN);
    case (state_d)
      ST_HOLD, ST_UNISO: req_n_d = 1'b0;
      ST_ISO, ST_UNRET: begin
        req_n_d = 1'b0;
        iso_n_d = 1'b0;
      end
      ST_RET, ST_PUP: begin
        req_n_d = 1'b0;
        iso_n_d = 1'b0;
        ret_n_d = 1'b0;
      end
      ST_PDN, ST_OFF: begin
        req_n_d = 1'b0;
        iso_n_d = 1'b0;
        ret_n_d = 1'b0;
        pdn_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (SRESET) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      wake_q  <= 1'b0;
      req_n_q <= 1'b1;
      iso_n_q <= 1'b1;
      ret_n_q <= 1'b1;
      pdn_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wake_q  <= wake_d;
      req_n_q <= req_n_d;
      iso_n_q <= iso_n_d;
      ret_n_q <= ret_n_d;
      pdn_q   <= pdn_d;
      busy_q  <= busy_d;
    end
  end

  assign SLEEPHOLDREQn = req_n_q;
  assign ISOLATEn      = iso_n_q;
  assign RETAINn       = ret_n_q;
  assign PWRDOWN       = pdn_q;
  assign PMUBUSY       = busy_q;

endmodule
